mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters: none; word width fixed at 64 bits, byte strobe width 8.
REQ-002 clk  in  1  single clock, rising-edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  execute-stage bundle present; held stable until accepted.
REQ-005 dataE  in  execute_data_t  pc, instruction, result (address), memdata, dst, ctl (memread, memwrite, msize, mem_unsigned, regwrite, csrwrite), ex_data.
REQ-006 ready_in  in  1  downstream (writeback) accepts dataM this cycle.
REQ-007 dreq_valid  out  1  data-bus request active.
REQ-008 dreq_addr  out  64  byte address (= dataE.result).
REQ-009 dreq_size  out  msize_t  access size.
REQ-010 dreq_strobe  out  8  byte-write enables; 0 for loads.
REQ-011 dreq_data  out  64  store data aligned to byte lane.
REQ-012 dresp_data_ok  in  1  bus completes the held request this cycle.
REQ-013 dresp_data  in  64  raw 64-bit read word.
REQ-014 data_ok  out  1  dataM valid; stage done.
REQ-015 dataM  out  memory_data_t  pc, instruction, dst, regwrite, csr fields, ex_data, result (ALU result or extended load data).

Function
REQ-016 FSM states IDLE, BUSY, HOLD.
REQ-017 IDLE, valid_in, no memread/memwrite, or ex_data.exception=1: data_ok=1 combinationally, dataM.result=dataE.result, no bus request; remain IDLE.
REQ-018 IDLE, valid_in, memread|memwrite, no exception: register request (addr, size, strobe, data, load flags) and go BUSY next edge.
REQ-019 BUSY: dreq_valid=1; all dreq_* stable from registers until dresp_data_ok.
REQ-020 BUSY with dresp_data_ok: capture extended load data (or pass address for stores), go HOLD; dreq_valid deasserts next cycle.
REQ-021 HOLD: data_ok=1, dataM stable; ready_in=1 -> IDLE; else remain HOLD.
REQ-022 Lane offset o=addr[2:0]; store data = memdata shifted left by 8*o; strobe: MSIZE1 0x01<<o, MSIZE2 0x03<<o, MSIZE4 0x0F<<o, MSIZE8 0xFF.
REQ-023 Load: extract byte/half/word/dword at lane o from dresp_data; sign-extend to 64 unless mem_unsigned=1 (zero-extend).
REQ-024 Misaligned addresses never reach the bus: execute flags them via ex_data, REQ-017 path applies.
REQ-025 Latency: minimum 2 cycles valid_in->data_ok for memory ops (1 BUSY cycle with immediate dresp_data_ok, then HOLD); 0 cycles for non-memory.
REQ-026 dresp_data_ok outside BUSY is ignored.
REQ-027 Exception carried in ex_data passes to dataM unchanged; stage adds none.

Reset
REQ-028 reset low: state=IDLE, dreq_valid=0, dreq_strobe=0, dreq_addr/data=0, data_ok=0, captured registers cleared, immediately and independent of clk.
REQ-029 Reset mid-BUSY abandons the request; no dresp handling until new IDLE acceptance.

Structure
REQ-030 memory_data_t and msize_t in pipes/common packages; FSM state enum local.
REQ-031 Single sub-module readdata (lane extract + sign/zero extension, combinational); strobe/store alignment inline.

Verification
REQ-032 SW addr 0x1004 data 0x11223344 -> strobe 0xF0, dreq_data 0x11223344_00000000, data_ok after dresp_data_ok.
REQ-033 LB addr 0x1003, dresp_data 0x00000000_80000000 -> dataM.result 0xFFFFFFFF_FFFFFF80; LBU -> 0x80.
REQ-034 LD with dresp_data_ok delayed 5 cycles -> dreq_* stable all 5 cycles, data_ok only after.
REQ-035 ADD (no mem), valid_in=1 -> data_ok same cycle, no dreq_valid.
REQ-036 HOLD with ready_in=0 for 3 cycles -> dataM stable, data_ok held; ready_in=1 -> IDLE.
REQ-037 Reset asserted during BUSY -> dreq_valid=0 immediately, late dresp_data_ok ignored, data_ok=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access pipeline stage: bus sizes, stage bundles
// and the store-lane alignment helpers.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic   memread;
        logic   memwrite;
        msize_t msize;
        logic   mem_unsigned;
        logic   regwrite;
        logic   csrwrite;
    } ctl_t;

    typedef struct packed {
        logic        exception;
        logic [4:0]  ecode;
        logic [11:0] csr_addr;
    } ex_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
        logic [63:0] result;
        logic [63:0] memdata;
        logic [4:0]  dst;
        ctl_t        ctl;
        ex_data_t    ex_data;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
        logic [4:0]  dst;
        logic        regwrite;
        logic        csrwrite;
        ex_data_t    ex_data;
        logic [63:0] result;
    } memory_data_t;

    function automatic logic [7:0] strobe_for(input msize_t size, input logic [2:0] off);
        logic [7:0] strb;
        case (size)
            MSIZE1:  strb = 8'h01 << off;
            MSIZE2:  strb = 8'h03 << off;
            MSIZE4:  strb = 8'h0F << off;
            MSIZE8:  strb = 8'hFF;
            default: strb = 8'h00;
        endcase
        return strb;
    endfunction

    function automatic logic [63:0] align_store(input logic [63:0] data, input logic [2:0] off);
        return data << {off, 3'b000};
    endfunction

endpackage

// File: rtl/mem_access_readdata.sv
// Load-data lane extraction with sign or zero extension to 64 bits.
module mem_access_readdata
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  offset_i,
    input  msize_t      size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    logic [63:0] lane_s;

    assign lane_s = rdata_i >> {offset_i, 3'b000};

    // Select the access width and extend from its top bit.
    always_comb begin
        data_o = lane_s;
        case (size_i)
            MSIZE1:  data_o = {{56{lane_s[7]  & ~unsigned_i}}, lane_s[7:0]};
            MSIZE2:  data_o = {{48{lane_s[15] & ~unsigned_i}}, lane_s[15:0]};
            MSIZE4:  data_o = {{32{lane_s[31] & ~unsigned_i}}, lane_s[31:0]};
            MSIZE8:  data_o = lane_s;
            default: data_o = lane_s;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues one data-bus request per load/store, waits for
// completion, and holds the result until writeback takes it.
module mem_access
    import mem_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  execute_data_t dataE,
    input  logic          ready_in,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output msize_t        dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [63:0]   dreq_data,
    input  logic          dresp_data_ok,
    input  logic [63:0]   dresp_data,
    output logic          data_ok,
    output memory_data_t  dataM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state_q;
    logic         dreq_valid_q;
    logic [63:0]  dreq_addr_q;
    msize_t       dreq_size_q;
    logic [7:0]   dreq_strobe_q;
    logic [63:0]  dreq_data_q;
    logic         memread_q;
    logic         unsigned_q;
    memory_data_t mdata_q;

    logic         is_mem_s;
    logic         bypass_s;
    logic [63:0]  load_ext_s;

    assign is_mem_s = dataE.ctl.memread | dataE.ctl.memwrite;
    assign bypass_s = valid_in & (~is_mem_s | dataE.ex_data.exception);

    mem_access_readdata u_readdata (
        .rdata_i    (dresp_data),
        .offset_i   (dreq_addr_q[2:0]),
        .size_i     (dreq_size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_ext_s)
    );

    // Stage FSM; every bus-facing output and the held result are registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= 64'd0;
            dreq_size_q   <= MSIZE1;
            dreq_strobe_q <= 8'h00;
            dreq_data_q   <= 64'd0;
            memread_q     <= 1'b0;
            unsigned_q    <= 1'b0;
            mdata_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in && is_mem_s && !dataE.ex_data.exception) begin
                        state_q             <= BUSY;
                        dreq_valid_q        <= 1'b1;
                        dreq_addr_q         <= dataE.result;
                        dreq_size_q         <= dataE.ctl.msize;
                        dreq_strobe_q       <= dataE.ctl.memwrite ?
                                               strobe_for(dataE.ctl.msize, dataE.result[2:0]) : 8'h00;
                        dreq_data_q         <= align_store(dataE.memdata, dataE.result[2:0]);
                        memread_q           <= dataE.ctl.memread;
                        unsigned_q          <= dataE.ctl.mem_unsigned;
                        mdata_q.pc          <= dataE.pc;
                        mdata_q.instruction <= dataE.instruction;
                        mdata_q.dst         <= dataE.dst;
                        mdata_q.regwrite    <= dataE.ctl.regwrite;
                        mdata_q.csrwrite    <= dataE.ctl.csrwrite;
                        mdata_q.ex_data     <= dataE.ex_data;
                        mdata_q.result      <= dataE.result;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (dresp_data_ok) begin
                        state_q        <= HOLD;
                        dreq_valid_q   <= 1'b0;
                        mdata_q.result <= memread_q ? load_ext_s : dreq_addr_q;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                HOLD: begin
                    if (ready_in) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    dreq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dreq_valid  = dreq_valid_q;
    assign dreq_addr   = dreq_addr_q;
    assign dreq_size   = dreq_size_q;
    assign dreq_strobe = dreq_strobe_q;
    assign dreq_data   = dreq_data_q;

    // Non-memory and faulting bundles complete in the same cycle; reset masks the bypass too.
    assign data_ok = reset & ((state_q == HOLD) | ((state_q == IDLE) & bypass_s));

    // Held result while HOLD, otherwise a straight pass-through of the execute bundle.
    always_comb begin
        dataM = '0;
        if (state_q == HOLD) begin
            dataM = mdata_q;
        end else begin
            dataM.pc          = dataE.pc;
            dataM.instruction = dataE.instruction;
            dataM.dst         = dataE.dst;
            dataM.regwrite    = dataE.ctl.regwrite;
            dataM.csrwrite    = dataE.ctl.csrwrite;
            dataM.ex_data     = dataE.ex_data;
            dataM.result      = dataE.result;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed table-driven bench for mem_access plus reset/idle corner sequences.
module tb_mem_access;
    import mem_access_pkg::*;

    logic          clk;
    logic          reset;
    logic          valid_in;
    execute_data_t dataE;
    logic          ready_in;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    msize_t        dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    logic          data_ok;
    memory_data_t  dataM;

    int n_pass = 0;
    int n_total = 0;

    mem_access dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .dataE         (dataE),
        .ready_in      (ready_in),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .data_ok       (data_ok),
        .dataM         (dataM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        msize_t      sz;
        logic        uns;
        logic        exc;
        logic [63:0] addr;
        logic [63:0] memdata;
        logic [63:0] rdata;
        int          delay;
        int          hold;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_result;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input string name, input logic rd, input logic wr, input msize_t sz,
                                input logic uns, input logic exc, input logic [63:0] addr,
                                input logic [63:0] memdata, input logic [63:0] rdata,
                                input int delay, input int hold, input logic [7:0] exp_strb,
                                input logic [63:0] exp_wdata, input logic [63:0] exp_result);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.exc = exc;
        v.addr = addr; v.memdata = memdata; v.rdata = rdata; v.delay = delay; v.hold = hold;
        v.exp_strb = exp_strb; v.exp_wdata = exp_wdata; v.exp_result = exp_result;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        dataE                  = '0;
        dataE.pc               = 64'h8000_0040;
        dataE.instruction      = 32'h0000_0013;
        dataE.result           = v.addr;
        dataE.memdata          = v.memdata;
        dataE.dst              = 5'd7;
        dataE.ctl.memread      = v.rd;
        dataE.ctl.memwrite     = v.wr;
        dataE.ctl.msize        = v.sz;
        dataE.ctl.mem_unsigned = v.uns;
        dataE.ctl.regwrite     = v.rd;
        dataE.ex_data.exception = v.exc;
        dataE.ex_data.ecode    = v.exc ? 5'd4 : 5'd0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v);
        ready_in = 1'b1;
        valid_in = 1'b1;
        #1;
        if (!(v.rd || v.wr) || v.exc) begin
            chk({v.name, "_ok"},     {63'd0, data_ok},    64'd1);
            chk({v.name, "_noreq"},  {63'd0, dreq_valid}, 64'd0);
            chk({v.name, "_result"}, dataM.result,        v.exp_result);
            chk({v.name, "_exc"},    {63'd0, dataM.ex_data.exception}, {63'd0, v.exc});
            @(posedge clk);
            #1 valid_in = 1'b0;
            @(negedge clk);
            chk({v.name, "_idle"},   {63'd0, dreq_valid}, 64'd0);
        end else begin
            chk({v.name, "_early_ok"}, {63'd0, data_ok}, 64'd0);
            @(posedge clk);
            #1 valid_in = 1'b0;
            dataE = '0;
            for (int c = 0; c <= v.delay; c++) begin
                @(negedge clk);
                chk({v.name, "_valid"},  {63'd0, dreq_valid}, 64'd1);
                chk({v.name, "_addr"},   dreq_addr,           v.addr);
                chk({v.name, "_size"},   {62'd0, dreq_size},  {62'd0, v.sz});
                chk({v.name, "_strobe"}, {56'd0, dreq_strobe}, {56'd0, v.exp_strb});
                if (v.wr) chk({v.name, "_wdata"}, dreq_data, v.exp_wdata);
                chk({v.name, "_busy_ok"}, {63'd0, data_ok}, 64'd0);
                dresp_data    = (c == v.delay) ? v.rdata : 64'hA5A5_A5A5_A5A5_A5A5;
                dresp_data_ok = (c == v.delay);
            end
            @(posedge clk);
            #1 dresp_data_ok = 1'b0;
            dresp_data = 64'h5A5A_5A5A_5A5A_5A5A;
            @(negedge clk);
            ready_in = (v.hold == 0);
            chk({v.name, "_ok"},     {63'd0, data_ok},    64'd1);
            chk({v.name, "_reqoff"}, {63'd0, dreq_valid}, 64'd0);
            chk({v.name, "_result"}, dataM.result,        v.exp_result);
            chk({v.name, "_dst"},    {59'd0, dataM.dst},  64'd7);
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                chk({v.name, "_hold_ok"},  {63'd0, data_ok}, 64'd1);
                chk({v.name, "_hold_res"}, dataM.result,     v.exp_result);
            end
            ready_in = 1'b1;
            @(negedge clk);
            chk({v.name, "_done"}, {63'd0, data_ok}, 64'd0);
        end
    endtask

    initial begin
        vecs[0]  = mk("sw",   1'b0, 1'b1, MSIZE4, 1'b0, 1'b0, 64'h1004, 64'h1122_3344, 64'd0, 0, 0,
                      8'hF0, 64'h1122_3344_0000_0000, 64'h1004);
        vecs[1]  = mk("lb",   1'b1, 1'b0, MSIZE1, 1'b0, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0,
                      8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[2]  = mk("lbu",  1'b1, 1'b0, MSIZE1, 1'b1, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0,
                      8'h00, 64'd0, 64'h80);
        vecs[3]  = mk("ld",   1'b1, 1'b0, MSIZE8, 1'b0, 1'b0, 64'h2000, 64'd0, 64'h0123_4567_89AB_CDEF, 5, 3,
                      8'h00, 64'd0, 64'h0123_4567_89AB_CDEF);
        vecs[4]  = mk("add",  1'b0, 1'b0, MSIZE8, 1'b0, 1'b0, 64'h55, 64'h1234, 64'd0, 0, 0,
                      8'h00, 64'd0, 64'h55);
        vecs[5]  = mk("lh",   1'b1, 1'b0, MSIZE2, 1'b0, 1'b0, 64'h1006, 64'd0, 64'h8001_0000_0000_0000, 1, 0,
                      8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_8001);
        vecs[6]  = mk("lwu",  1'b1, 1'b0, MSIZE4, 1'b1, 1'b0, 64'h1004, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 0,
                      8'h00, 64'd0, 64'h0000_0000_DEAD_BEEF);
        vecs[7]  = mk("lw",   1'b1, 1'b0, MSIZE4, 1'b0, 1'b0, 64'h1004, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 1,
                      8'h00, 64'd0, 64'hFFFF_FFFF_DEAD_BEEF);
        vecs[8]  = mk("sb",   1'b0, 1'b1, MSIZE1, 1'b0, 1'b0, 64'h1007, 64'hAB, 64'd0, 0, 0,
                      8'h80, 64'hAB00_0000_0000_0000, 64'h1007);
        vecs[9]  = mk("sh",   1'b0, 1'b1, MSIZE2, 1'b0, 1'b0, 64'h1002, 64'hBEEF, 64'd0, 2, 0,
                      8'h0C, 64'h0000_0000_BEEF_0000, 64'h1002);
        vecs[10] = mk("misal", 1'b1, 1'b0, MSIZE4, 1'b0, 1'b1, 64'h1001, 64'd0, 64'd0, 0, 0,
                      8'h00, 64'd0, 64'h1001);

        reset         = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 64'd0;
        ready_in      = 1'b1;
        drive(vecs[4]);
        valid_in      = 1'b1;
        #3;
        chk("rst_valid",  {63'd0, dreq_valid},  64'd0);
        chk("rst_ok",     {63'd0, data_ok},     64'd0);
        chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
        chk("rst_addr",   dreq_addr,            64'd0);
        chk("rst_data",   dreq_data,            64'd0);
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Stray completion while idle must not produce a result.
        @(negedge clk);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("stray_ok",    {63'd0, data_ok},    64'd0);
        chk("stray_valid", {63'd0, dreq_valid}, 64'd0);

        // Reset while a load is outstanding, then a late completion.
        @(negedge clk);
        drive(vecs[3]);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        chk("rbusy_valid", {63'd0, dreq_valid}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rbusy_drop",   {63'd0, dreq_valid},  64'd0);
        chk("rbusy_ok",     {63'd0, data_ok},     64'd0);
        chk("rbusy_addr",   dreq_addr,            64'd0);
        @(negedge clk);
        reset         = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1 dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("late_ok",    {63'd0, data_ok},    64'd0);
        chk("late_valid", {63'd0, dreq_valid}, 64'd0);
        @(negedge clk);
        chk("late_ok2",   {63'd0, data_ok},    64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
